// File: rtl/mag_cmp_pkg.sv
// Shared types and helpers for the bit-serial magnitude comparator.
package mag_cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        RES_EQ = 2'd0,
        RES_GT = 2'd1,
        RES_LT = 2'd2
    } cmp_res_t;

    function automatic int clog2(input int value);
        int r;
        r = 32'sd0;
        while ((32'sd1 <<< r) < value) begin
            r = r + 32'sd1;
        end
        return r;
    endfunction

    // Flag vector ordering is {gt, lt, eq}; an illegal code reads as equal.
    function automatic logic [2:0] res_to_flags(input cmp_res_t res);
        logic [2:0] flags;
        case (res)
            RES_GT:  flags = 3'b100;
            RES_LT:  flags = 3'b010;
            RES_EQ:  flags = 3'b001;
            default: flags = 3'b001;
        endcase
        return flags;
    endfunction

endpackage

// File: rtl/cmp_bit_cell.sv
// Combinational single-bit compare cell with one-hot gt/lt/eq outputs.
module cmp_bit_cell (
    input  logic a_bit,
    input  logic b_bit,
    output logic gt,
    output logic lt,
    output logic eq
);

    // One-hot compare of a single bit pair.
    always_comb begin
        gt = 1'b0;
        lt = 1'b0;
        eq = 1'b0;
        if (a_bit == b_bit) begin
            eq = 1'b1;
        end else if (a_bit == 1'b1) begin
            gt = 1'b1;
        end else begin
            lt = 1'b1;
        end
    end

endmodule

// File: rtl/serial_mag_comp.sv
// Bit-serial unsigned magnitude comparator: scans MSB-first through one
// compare cell and returns a one-hot gt/lt/eq result with the scan length.
module serial_mag_comp
    import mag_cmp_pkg::*;
#(
    parameter int W          = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [W-1:0]                    a,
    input  logic [W-1:0]                    b,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            a_gt_b,
    output logic                            a_lt_b,
    output logic                            a_eq_b,
    output logic [clog2(W + 32'sd1)-1:0]    scan_cycles
);

    localparam int CW = clog2(W + 32'sd1);
    localparam int IW = clog2(W);

    state_t         state_r, state_nxt_s;
    logic [W-1:0]   a_sh_r, a_sh_nxt_s;
    logic [W-1:0]   b_sh_r, b_sh_nxt_s;
    logic [IW-1:0]  idx_r, idx_nxt_s;
    logic [CW-1:0]  cnt_r, cnt_nxt_s;
    cmp_res_t       sticky_r, sticky_nxt_s;
    logic           in_ready_r, in_ready_nxt_s;
    logic           out_valid_r, out_valid_nxt_s;
    logic [2:0]     flags_r, flags_nxt_s;
    logic [CW-1:0]  scan_r, scan_nxt_s;

    logic           cell_gt_s, cell_lt_s, cell_eq_s;
    cmp_res_t       cell_res_s;
    cmp_res_t       sticky_eff_s;
    logic           finish_s;

    cmp_bit_cell u_cell (
        .a_bit (a_sh_r[W-1]),
        .b_bit (b_sh_r[W-1]),
        .gt    (cell_gt_s),
        .lt    (cell_lt_s),
        .eq    (cell_eq_s)
    );

    // Encode the cell result and merge it with any earlier difference.
    always_comb begin
        case ({cell_gt_s, cell_lt_s, cell_eq_s})
            3'b100:  cell_res_s = RES_GT;
            3'b010:  cell_res_s = RES_LT;
            default: cell_res_s = RES_EQ;
        endcase
        if (sticky_r != RES_EQ) begin
            sticky_eff_s = sticky_r;
        end else begin
            sticky_eff_s = cell_res_s;
        end
        // With early exit the sticky register never holds a difference,
        // so sticky_eff_s is simply the current cell result.
        finish_s = ((EARLY_EXIT == 1'b1) && (cell_res_s != RES_EQ)) ||
                   (idx_r == {IW{1'b0}});
    end

    // Next-state and next-output logic of the scan FSM.
    always_comb begin
        state_nxt_s     = state_r;
        a_sh_nxt_s      = a_sh_r;
        b_sh_nxt_s      = b_sh_r;
        idx_nxt_s       = idx_r;
        cnt_nxt_s       = cnt_r;
        sticky_nxt_s    = sticky_r;
        in_ready_nxt_s  = in_ready_r;
        out_valid_nxt_s = out_valid_r;
        flags_nxt_s     = flags_r;
        scan_nxt_s      = scan_r;
        case (state_r)
            IDLE: begin
                if (in_valid && in_ready_r) begin
                    a_sh_nxt_s     = a;
                    b_sh_nxt_s     = b;
                    idx_nxt_s      = IW'(W - 32'sd1);
                    cnt_nxt_s      = {CW{1'b0}};
                    sticky_nxt_s   = RES_EQ;
                    in_ready_nxt_s = 1'b0;
                    state_nxt_s    = SCAN;
                end else begin
                    in_ready_nxt_s = 1'b1;
                end
            end
            SCAN: begin
                a_sh_nxt_s   = {a_sh_r[W-2:0], 1'b0};
                b_sh_nxt_s   = {b_sh_r[W-2:0], 1'b0};
                idx_nxt_s    = idx_r - IW'(1'b1);
                cnt_nxt_s    = cnt_r + CW'(1'b1);
                sticky_nxt_s = sticky_eff_s;
                if (finish_s) begin
                    out_valid_nxt_s = 1'b1;
                    flags_nxt_s     = res_to_flags(sticky_eff_s);
                    scan_nxt_s      = cnt_r + CW'(1'b1);
                    state_nxt_s     = DONE;
                end else begin
                    state_nxt_s     = SCAN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_nxt_s = 1'b0;
                    flags_nxt_s     = 3'b000;
                    scan_nxt_s      = {CW{1'b0}};
                    in_ready_nxt_s  = 1'b1;
                    state_nxt_s     = IDLE;
                end else begin
                    state_nxt_s     = DONE;
                end
            end
            default: begin
                out_valid_nxt_s = 1'b0;
                flags_nxt_s     = 3'b000;
                scan_nxt_s      = {CW{1'b0}};
                in_ready_nxt_s  = 1'b1;
                state_nxt_s     = IDLE;
            end
        endcase
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            a_sh_r      <= {W{1'b0}};
            b_sh_r      <= {W{1'b0}};
            idx_r       <= {IW{1'b0}};
            cnt_r       <= {CW{1'b0}};
            sticky_r    <= RES_EQ;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            flags_r     <= 3'b000;
            scan_r      <= {CW{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            a_sh_r      <= a_sh_nxt_s;
            b_sh_r      <= b_sh_nxt_s;
            idx_r       <= idx_nxt_s;
            cnt_r       <= cnt_nxt_s;
            sticky_r    <= sticky_nxt_s;
            in_ready_r  <= in_ready_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            flags_r     <= flags_nxt_s;
            scan_r      <= scan_nxt_s;
        end
    end

    assign in_ready    = in_ready_r;
    assign out_valid   = out_valid_r;
    assign a_gt_b      = flags_r[2];
    assign a_lt_b      = flags_r[1];
    assign a_eq_b      = flags_r[0];
    assign scan_cycles = scan_r;

endmodule

// File: tb/tb_serial_mag_comp.sv
// Scoreboard bench for serial_mag_comp with early-exit and full-scan instances.
module tb_serial_mag_comp;

    localparam int W  = 8;
    localparam int CW = 4;

    typedef struct packed {
        logic          gt;
        logic          lt;
        logic          eq;
        logic [CW-1:0] scan;
    } res_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_ready = 1'b0;
    logic         use_ee0 = 1'b0;

    logic          in_ready1, out_valid1, gt1, lt1, eq1;
    logic [CW-1:0] scan1;
    logic          in_ready0, out_valid0, gt0, lt0, eq0;
    logic [CW-1:0] scan0;

    logic in_ready_m, out_valid_m;
    res_t obs_m;

    res_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   acc_cyc = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    serial_mag_comp #(.W(W), .EARLY_EXIT(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid & ~use_ee0), .in_ready(in_ready1),
        .a(a), .b(b),
        .out_valid(out_valid1), .out_ready(use_ee0 ? 1'b1 : out_ready),
        .a_gt_b(gt1), .a_lt_b(lt1), .a_eq_b(eq1), .scan_cycles(scan1)
    );

    serial_mag_comp #(.W(W), .EARLY_EXIT(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid & use_ee0), .in_ready(in_ready0),
        .a(a), .b(b),
        .out_valid(out_valid0), .out_ready(use_ee0 ? out_ready : 1'b1),
        .a_gt_b(gt0), .a_lt_b(lt0), .a_eq_b(eq0), .scan_cycles(scan0)
    );

    assign in_ready_m  = use_ee0 ? in_ready0 : in_ready1;
    assign out_valid_m = use_ee0 ? out_valid0 : out_valid1;
    assign obs_m       = use_ee0 ? {gt0, lt0, eq0, scan0} : {gt1, lt1, eq1, scan1};

    function automatic res_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input bit ee);
        res_t e;
        int   k;
        k = -1;
        for (int i = W - 1; i >= 0; i--) begin
            if (k < 0 && av[i] != bv[i]) k = i;
        end
        e.gt   = (av > bv);
        e.lt   = (av < bv);
        e.eq   = (av == bv);
        e.scan = (ee && k >= 0) ? CW'(W - k) : CW'(W);
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a pair, wait for in_ready, push the expectation at the accept edge.
    task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv);
        int t;
        t = 0;
        a = av;
        b = bv;
        in_valid = 1'b1;
        while (!in_ready_m && t < 100) begin
            tick();
            t++;
        end
        if (!in_ready_m) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout in_ready got 0 want 1 within 100 cycles");
        end
        exp_q.push_back(model(av, bv, !use_ee0));
        tick();
        acc_cyc = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_result(output res_t obs, output int lat);
        int t;
        t = 0;
        while (!out_valid_m && t < 100) begin
            tick();
            t++;
        end
        if (!out_valid_m) begin
            n_cmp++;
            n_bad++;
            $display("FAIL result_timeout out_valid got 0 want 1 within 100 cycles");
        end
        obs = obs_m;
        lat = cyc - acc_cyc;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        use_ee0 = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        n_cmp++;
        if ({in_ready1, out_valid1} !== 2'b10) begin
            n_bad++;
            $display("FAIL reset_handshake1 got %b want 10", {in_ready1, out_valid1});
        end
        n_cmp++;
        if ({gt1, lt1, eq1, scan1} !== 7'd0) begin
            n_bad++;
            $display("FAIL reset_result1 got %b want 0000000", {gt1, lt1, eq1, scan1});
        end
        n_cmp++;
        if ({in_ready0, out_valid0, gt0, lt0, eq0, scan0} !== 9'b10_0000000) begin
            n_bad++;
            $display("FAIL reset_dut0 got %b want 100000000", {in_ready0, out_valid0, gt0, lt0, eq0, scan0});
        end
    endtask

    // Directed pairs on one instance; each result is released immediately.
    task automatic test_directed(input bit ee0, input logic [W-1:0] av [3], input logic [W-1:0] bv [3]);
        res_t obs, e;
        int   lat;
        use_ee0 = ee0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send(av[i], bv[i]);
            wait_result(obs, lat);
            e = exp_q.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL directed_result ee0=%0b a=%h b=%h got %h want %h", ee0, av[i], bv[i], obs, e);
            end
            n_cmp++;
            if (lat !== int'(e.scan)) begin
                n_bad++;
                $display("FAIL directed_latency ee0=%0b a=%h b=%h got %0d want %0d", ee0, av[i], bv[i], lat, e.scan);
            end
            tick();
            n_cmp++;
            if ({out_valid_m, obs_m.gt, obs_m.lt, obs_m.eq} !== 4'b0000) begin
                n_bad++;
                $display("FAIL directed_clear got %b want 0000", {out_valid_m, obs_m.gt, obs_m.lt, obs_m.eq});
            end
        end
    endtask

    task automatic test_early_exit();
        logic [W-1:0] av [3] = '{8'h80, 8'h5A, 8'hC3};
        logic [W-1:0] bv [3] = '{8'h7F, 8'h5B, 8'hC3};
        test_directed(1'b0, av, bv);
    endtask

    task automatic test_full_scan();
        logic [W-1:0] av [3] = '{8'h80, 8'h80, 8'h0F};
        logic [W-1:0] bv [3] = '{8'h00, 8'h01, 8'h0E};
        test_directed(1'b1, av, bv);
    endtask

    task automatic test_backpressure();
        res_t obs, e, held;
        int   lat;
        use_ee0 = 1'b0;
        out_ready = 1'b0;
        send(8'h3C, 8'h3D);
        wait_result(held, lat);
        e = exp_q.pop_front();
        n_cmp++;
        if (held !== e) begin
            n_bad++;
            $display("FAIL bp_result got %h want %h", held, e);
        end
        a = 8'h11;
        b = 8'h22;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if ({out_valid_m, in_ready_m, obs_m} !== {1'b1, 1'b0, held}) begin
                n_bad++;
                $display("FAIL bp_hold cycle %0d got %b want %b", i, {out_valid_m, in_ready_m, obs_m}, {1'b1, 1'b0, held});
            end
        end
        out_ready = 1'b1;
        tick();
        n_cmp++;
        if ({out_valid_m, in_ready_m, obs_m.gt, obs_m.lt, obs_m.eq} !== 5'b01000) begin
            n_bad++;
            $display("FAIL bp_release got %b want 01000", {out_valid_m, in_ready_m, obs_m.gt, obs_m.lt, obs_m.eq});
        end
        send(8'h11, 8'h22);
        wait_result(obs, lat);
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e || lat !== int'(e.scan)) begin
            n_bad++;
            $display("FAIL bp_pending got %h lat %0d want %h lat %0d", obs, lat, e, e.scan);
        end
        tick();
    endtask

    task automatic test_reset_mid_scan();
        res_t obs, e;
        int   lat;
        use_ee0 = 1'b1;
        out_ready = 1'b1;
        send(8'h0F, 8'hF0);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_q.delete();
        n_cmp++;
        if ({in_ready_m, out_valid_m, obs_m} !== {2'b10, 7'd0}) begin
            n_bad++;
            $display("FAIL midscan_reset got %b want 100000000", {in_ready_m, out_valid_m, obs_m});
        end
        tick();
        n_cmp++;
        if (out_valid_m !== 1'b0) begin
            n_bad++;
            $display("FAIL midscan_no_partial out_valid got %b want 0", out_valid_m);
        end
        send(8'h0F, 8'hF0);
        wait_result(obs, lat);
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e || lat !== int'(e.scan)) begin
            n_bad++;
            $display("FAIL midscan_fresh got %h lat %0d want %h lat %0d", obs, lat, e, e.scan);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        res_t         obs, e;
        int           lat;
        logic [W-1:0] av, bv;
        for (int p = 0; p < 1000; p++) begin
            use_ee0 = (p % 3 == 2);
            out_ready = 1'b0;
            av = W'($urandom);
            case ($urandom_range(0, 3))
                0:       bv = av;
                1:       bv = av ^ (8'h01 << $urandom_range(0, 7));
                default: bv = W'($urandom);
            endcase
            send(av, bv);
            wait_result(obs, lat);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL b2b_queue_empty pair %0d", p);
            end else begin
                e = exp_q.pop_front();
                n_cmp++;
                if (obs !== e) begin
                    n_bad++;
                    $display("FAIL b2b_result pair %0d a=%h b=%h got %h want %h", p, av, bv, obs, e);
                end
                n_cmp++;
                if (lat !== int'(e.scan)) begin
                    n_bad++;
                    $display("FAIL b2b_latency pair %0d got %0d want %0d", p, lat, e.scan);
                end
            end
            n_cmp++;
            if ($countones({obs_m.gt, obs_m.lt, obs_m.eq}) !== 1) begin
                n_bad++;
                $display("FAIL b2b_onehot pair %0d got %b want one-hot", p, {obs_m.gt, obs_m.lt, obs_m.eq});
            end
            out_ready = ($urandom_range(0, 1) == 1);
            while (!out_ready) begin
                tick();
                n_cmp++;
                if ({out_valid_m, obs_m} !== {1'b1, obs}) begin
                    n_bad++;
                    $display("FAIL b2b_stall pair %0d got %b want %b", p, {out_valid_m, obs_m}, {1'b1, obs});
                end
                out_ready = ($urandom_range(0, 3) != 0);
            end
            tick();
            n_cmp++;
            if (out_valid_m !== 1'b0) begin
                n_bad++;
                $display("FAIL b2b_release pair %0d out_valid got %b want 0", p, out_valid_m);
            end
        end
    endtask

    initial begin
        test_reset();
        test_early_exit();
        test_full_scan();
        test_backpressure();
        test_reset_mid_scan();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

endmodule
